rom_rd_arbiter: RTL and testbench

- Shares one read-only lookup table (8 x 4-bit, synchronous read) between NUM_REQ independent requesters.
- Each requester uses a valid/ready address handshake. Accepted reads are arbitrated round-robin and issued one at a time.
- The read latency is counted, then the data is returned to the owning requester with a one-cycle response pulse.
- Sits between the lookup table and its client blocks, so no client drives the table address directly.

---
 rtl/rom_arb_pkg.sv | 19 +
 rtl/rom_rd_arbiter_rr_pick.sv | 40 ++++
 rtl/rom_rd_arbiter.sv | 91 +++++++++
 tb/tb_rom_rd_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/rom_arb_pkg.sv
// rtl/rom_arb_pkg.sv - shared state encoding, default sizes and counter width helper for rom_rd_arbiter
package rom_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  localparam int ROM_ADDR_W = 3;
  localparam int ROM_DATA_W = 4;
  localparam int ROM_RD_LAT = 1;

  // One extra bit so the counter can hold RD_LAT itself without wrapping.
  function automatic int lat_cnt_w(input int rd_lat);
    return $clog2(rd_lat) + 1;
  endfunction

endpackage

// File: rtl/rom_rd_arbiter_rr_pick.sv
// rtl/rom_rd_arbiter_rr_pick.sv - combinational requester selector; ROM_ARB_FIXED_PRIO_EN selects fixed priority
module rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  int   idx;
  logic found;

`ifdef ROM_ARB_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = ^last_grant;
`endif

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
`ifdef ROM_ARB_FIXED_PRIO_EN
      idx = k;
`else
      // Search starts just after the previous winner so it ends up last in line.
      idx = (int'(last_grant) + 1 + k) % N;
`endif
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rom_rd_arbiter.sv
// rtl/rom_rd_arbiter.sv - shares one synchronous-read table among NUM_REQ requesters (ROM_ARB_FIXED_PRIO_EN: fixed priority)
module rom_rd_arbiter
  import rom_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = ROM_ADDR_W,
  parameter int DATA_W  = ROM_DATA_W,
  parameter int RD_LAT  = ROM_RD_LAT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      busy,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_data
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = lat_cnt_w(RD_LAT);
  localparam logic [CNT_W-1:0] LAT_END = CNT_W'(RD_LAT);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_WAIT = WAIT;
  localparam logic [1:0] S_RESP = RESP;

  logic [1:0]         state;
  logic [CNT_W-1:0]   lat_cnt;
  logic [IDX_W-1:0]   last_grant;
  logic [IDX_W-1:0]   owner;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  assign req_ready = (state == S_IDLE) ? grant : '0;

  // Address registered at the accept edge; table data is sampled RD_LAT+1 edges later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      lat_cnt    <= '0;
      last_grant <= IDX_W'(NUM_REQ - 1);
      owner      <= '0;
      rom_addr   <= '0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|(req_valid & req_ready)) begin
            rom_addr   <= req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
            owner      <= grant_idx;
            last_grant <= grant_idx;
            lat_cnt    <= '0;
            busy       <= 1'b1;
            state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (lat_cnt == LAT_END) begin
            rsp_data  <= rom_data;
            rsp_valid <= NUM_REQ'(1) << owner;
            state     <= S_RESP;
          end else begin
            lat_cnt <= lat_cnt + CNT_W'(1);
          end
        end
        S_RESP: begin
          rsp_valid <= '0;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_rd_arbiter.sv
// tb/tb_rom_rd_arbiter.sv - scoreboard bench for rom_rd_arbiter (RD_LAT=1 and RD_LAT=3 instances)
module tb_rom_rd_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req_valid1, req_ready1, rsp_valid1;
  logic [5:0] req_addr1;
  logic [3:0] rsp_data1, rom_data1;
  logic [2:0] rom_addr1;
  logic       busy1;
  logic [1:0] req_valid3, req_ready3, rsp_valid3;
  logic [5:0] req_addr3;
  logic [3:0] rsp_data3, rom_data3;
  logic [2:0] rom_addr3;
  logic       busy3;

  always #5 clk = ~clk;

  rom_rd_arbiter #(.NUM_REQ(2), .ADDR_W(3), .DATA_W(4), .RD_LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_addr(req_addr1),
    .req_ready(req_ready1), .rsp_valid(rsp_valid1), .rsp_data(rsp_data1),
    .busy(busy1), .rom_addr(rom_addr1), .rom_data(rom_data1));

  rom_rd_arbiter #(.NUM_REQ(2), .ADDR_W(3), .DATA_W(4), .RD_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_addr(req_addr3),
    .req_ready(req_ready3), .rsp_valid(rsp_valid3), .rsp_data(rsp_data3),
    .busy(busy3), .rom_addr(rom_addr3), .rom_data(rom_data3));

  // Table model rom[k] = 2k with RD_LAT register stages after the address.
  logic [3:0] p1, p3a, p3b, p3c;
  always @(posedge clk) begin
    p1  <= {rom_addr1, 1'b0};
    p3a <= {rom_addr3, 1'b0};
    p3b <= p3a;
    p3c <= p3b;
  end
  assign rom_data1 = p1;
  assign rom_data3 = p3c;

  typedef struct {int idx; int data; int due;} exp_t;
  exp_t sb1[$];
  exp_t sb3[$];
  int   glog1[$];
  int   glog3[$];
  int   checks = 0;
  int   failures = 0;
  int   ncyc = 0;
  int   nrsp1 = 0;
  exp_t e1, e3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Responses are popped and compared; accepts push the expected response.
  always @(negedge clk) begin
    ncyc++;
    if (rsp_valid1 !== 2'b00) begin
      nrsp1++;
      if (sb1.size() == 0) chk("rsp1_unexpected", rsp_valid1, 0);
      else begin
        e1 = sb1.pop_front();
        chk("rsp1_valid", rsp_valid1, 1 << e1.idx);
        chk("rsp1_data", rsp_data1, e1.data);
        chk("rsp1_time", ncyc, e1.due);
      end
    end
    if ((req_valid1 & req_ready1) != 2'b00) begin
      e1.idx  = req_ready1[1] ? 1 : 0;
      e1.data = 2 * (e1.idx == 1 ? int'(req_addr1[5:3]) : int'(req_addr1[2:0]));
      e1.due  = ncyc + 3;
      sb1.push_back(e1);
      glog1.push_back(e1.idx);
    end
    if (rsp_valid3 !== 2'b00) begin
      if (sb3.size() == 0) chk("rsp3_unexpected", rsp_valid3, 0);
      else begin
        e3 = sb3.pop_front();
        chk("rsp3_valid", rsp_valid3, 1 << e3.idx);
        chk("rsp3_data", rsp_data3, e3.data);
        chk("rsp3_time", ncyc, e3.due);
      end
    end
    if ((req_valid3 & req_ready3) != 2'b00) begin
      e3.idx  = req_ready3[1] ? 1 : 0;
      e3.data = 2 * (e3.idx == 1 ? int'(req_addr3[5:3]) : int'(req_addr3[2:0]));
      e3.due  = ncyc + 5;
      sb3.push_back(e3);
      glog3.push_back(e3.idx);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_grants1(input int n, input int budget);
    int b = 0;
    while (glog1.size() < n && b < budget) begin
      tick(1);
      b++;
    end
    if (glog1.size() < n) chk("wait_grants1_timeout", glog1.size(), n);
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0;
    req_valid1 = '0; req_addr1 = '0;
    req_valid3 = '0; req_addr3 = '0;
    tick(2);
    chk("rst_rsp_valid", rsp_valid1, 0);
    chk("rst_rsp_data", rsp_data1, 0);
    chk("rst_rom_addr", rom_addr1, 0);
    chk("rst_busy", busy1, 0);
    rst_n = 1'b1;
    tick(2);

    // Single request, addr 5 -> 10
    req_addr1 = {3'd0, 3'd5};
    req_valid1 = 2'b01;
    #1;
    chk("t1_ready", req_ready1, 2'b01);
    tick(1);
    req_valid1 = 2'b00;
    req_valid1 = 2'b01;
    chk("t1_ready_wait", req_ready1, 2'b00);
    req_valid1 = 2'b00;
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      if (busy1) cnt++;
      tick(1);
    end
    chk("t1_busy_cycles", cnt, 3);
    chk("t1_drained", sb1.size(), 0);
    chk("t1_rsp_hold", rsp_data1, 10);

    // Reset in the cycle after accepting addr 4
    req_addr1 = {3'd0, 3'd4};
    req_valid1 = 2'b01;
    tick(1);
    req_valid1 = 2'b00;
    rst_n = 1'b0;
    #1;
    sb1.delete();
    glog1.delete();
    chk("mrst_busy", busy1, 0);
    chk("mrst_rom_addr", rom_addr1, 0);
    chk("mrst_rsp_valid", rsp_valid1, 0);
    chk("mrst_rsp_data", rsp_data1, 0);
    tick(2);
    rst_n = 1'b1;
    tick(4);
    chk("mrst_no_rsp", sb1.size(), 0);

    // Continuous contention, addr0=1 addr1=3
    req_addr1 = {3'd3, 3'd1};
    req_valid1 = 2'b11;
    wait_grants1(4, 40);
    req_valid1 = 2'b00;
    tick(6);
    for (int k = 0; k < 4; k++) begin
`ifdef ROM_ARB_FIXED_PRIO_EN
      chk($sformatf("cont_grant%0d", k), (glog1.size() > k) ? glog1[k] : -1, 0);
`else
      chk($sformatf("cont_grant%0d", k), (glog1.size() > k) ? glog1[k] : -1, k % 2);
`endif
    end

    // Requester 1 alone
    glog1.delete();
    req_valid1 = 2'b10;
    wait_grants1(1, 20);
    req_valid1 = 2'b00;
    tick(6);
    chk("solo1_grant", (glog1.size() > 0) ? glog1[0] : -1, 1);

    // Requester 0 alone twice: re-granted although just served
    glog1.delete();
    req_addr1 = {3'd3, 3'd6};
    req_valid1 = 2'b01;
    wait_grants1(2, 30);
    req_valid1 = 2'b00;
    tick(6);
    chk("again_cnt", glog1.size(), 2);
    chk("again_grant", (glog1.size() > 1) ? glog1[1] : -1, 0);

    // Requester 1 pulses during WAIT and withdraws
    glog1.delete();
    req_addr1 = {3'd5, 3'd2};
    req_valid1 = 2'b01;
    wait_grants1(1, 10);
    req_valid1 = 2'b10;
    chk("wd_ready", req_ready1, 2'b00);
    tick(1);
    req_valid1 = 2'b00;
    tick(6);
    chk("wd_grants", glog1.size(), 1);
    chk("wd_grant0", (glog1.size() > 0) ? glog1[0] : -1, 0);

    // RD_LAT=3 instance, addr 7 -> 14 on the 5th cycle
    req_addr3 = {3'd0, 3'd7};
    req_valid3 = 2'b01;
    cnt = 0;
    while (glog3.size() < 1 && cnt < 10) begin
      tick(1);
      cnt++;
    end
    chk("lat3_accepted", glog3.size(), 1);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("lat3_ready%0d", k), req_ready3, 2'b00);
      if (k == 4) req_valid3 = 2'b00;
      tick(1);
    end
    tick(3);

    chk("end_sb1_empty", sb1.size(), 0);
    chk("end_sb3_empty", sb3.size(), 0);
    chk("end_rsp1_count", nrsp1, 9);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
